// File: rtl/hazard_scoreboard.sv
// Decode-side data-hazard scoreboard: per-register countdown until an in-flight result
// is forwardable, plus a privileged issue block after control-flag writes.
module hazard_scoreboard #(
    parameter int REGTAG_SIZE    = 4,
    parameter int NUM_READ_PORTS = 4,
    parameter int MAX_LATENCY    = 7,
    parameter int CTRL_LATENCY   = 2,
    localparam int NUM_REGS      = 2**REGTAG_SIZE,
    localparam int LAT_W         = $clog2(MAX_LATENCY + 1),
    localparam int CTRL_W        = $clog2(CTRL_LATENCY + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_READ_PORTS-1:0][REGTAG_SIZE-1:0] readRegTag,
    input  logic [NUM_READ_PORTS-1:0]                  readEnable,
    input  logic                                       issueValid,
    input  logic                                       issueWritesReg,
    input  logic [REGTAG_SIZE-1:0]                     issueRegTag,
    input  logic [LAT_W-1:0]                           issueLatency,
    input  logic                                       issueSetsControlFlags,
    input  logic                                       privilegeLevel,
    input  logic                                       freeze,
    input  logic                                       flush,
    output logic                                       stall,
    output logic [NUM_READ_PORTS-1:0]                  hazardPort,
    output logic [NUM_REGS-1:0]                        pendingMask
);

    localparam logic [LAT_W-1:0]  MAX_LAT  = LAT_W'(MAX_LATENCY);
    localparam logic [CTRL_W-1:0] CTRL_LAT = CTRL_W'(CTRL_LATENCY);

    logic [NUM_REGS-1:0][LAT_W-1:0] counter_q;
    logic [NUM_REGS-1:0][LAT_W-1:0] counter_d;
    logic [CTRL_W-1:0]              ctrl_q;
    logic [CTRL_W-1:0]              ctrl_d;
    logic                           ctrl_hazard;
    logic                           accept;
    logic [LAT_W-1:0]               clamped_lat;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        hazardPort  = '0;
        pendingMask = '0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            hazardPort[i] = readEnable[i] && (counter_q[readRegTag[i]] != '0);
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            pendingMask[r] = (counter_q[r] != '0);
        end
    end

    assign ctrl_hazard = privilegeLevel && (ctrl_q != '0);
    assign stall       = freeze || (issueValid && ((|hazardPort) || ctrl_hazard));
    assign accept      = issueValid && !stall && !flush;
    assign clamped_lat = (issueLatency > MAX_LAT) ? MAX_LAT : issueLatency;

    always_comb begin
        counter_d = counter_q;
        ctrl_d    = ctrl_q;
        if (!freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                counter_d[r] = (counter_q[r] != '0) ? counter_q[r] - 1'b1 : '0;
                // Max rule: a younger short-latency writer never shortens an older entry.
                if (accept && issueWritesReg && (issueRegTag == REGTAG_SIZE'(r))
                    && (clamped_lat > counter_d[r])) begin
                    counter_d[r] = clamped_lat;
                end
            end
            if (accept && issueSetsControlFlags) begin
                ctrl_d = CTRL_LAT;
            end else if (ctrl_q != '0) begin
                ctrl_d = ctrl_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (reset) begin
            // NOTE: the counter array is control state, not a data RAM, so it must be reset.
            counter_q <= '0;
            ctrl_q    <= '0;
        end else begin
            counter_q <= counter_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a ready-time model,
// driving a default instance and a MAX_LATENCY=6 instance with identical inputs.
module tb_hazard_scoreboard;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0][3:0] readRegTag;
    logic [3:0]      readEnable;
    logic            issueValid;
    logic            issueWritesReg;
    logic [3:0]      issueRegTag;
    logic [2:0]      issueLatency;
    logic            issueSetsControlFlags;
    logic            privilegeLevel;
    logic            freeze;
    logic            flush;

    logic            stall0, stall1;
    logic [3:0]      hz0, hz1;
    logic [15:0]     pm0, pm1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut0 (
        .clk(clk), .reset(reset), .readRegTag(readRegTag), .readEnable(readEnable),
        .issueValid(issueValid), .issueWritesReg(issueWritesReg), .issueRegTag(issueRegTag),
        .issueLatency(issueLatency), .issueSetsControlFlags(issueSetsControlFlags),
        .privilegeLevel(privilegeLevel), .freeze(freeze), .flush(flush),
        .stall(stall0), .hazardPort(hz0), .pendingMask(pm0)
    );

    hazard_scoreboard #(.MAX_LATENCY(6)) dut1 (
        .clk(clk), .reset(reset), .readRegTag(readRegTag), .readEnable(readEnable),
        .issueValid(issueValid), .issueWritesReg(issueWritesReg), .issueRegTag(issueRegTag),
        .issueLatency(issueLatency), .issueSetsControlFlags(issueSetsControlFlags),
        .privilegeLevel(privilegeLevel), .freeze(freeze), .flush(flush),
        .stall(stall1), .hazardPort(hz1), .pendingMask(pm1)
    );

    // Model: a virtual clock that only advances on unfrozen cycles; each register
    // and the control block hold the virtual time at which they become free.
    longint m_ready [2][16];
    longint m_ctrl  [2];
    longint m_vt;
    bit     model_ok = 1'b0;
    int     maxl    [2] = '{7, 6};

    function automatic logic [15:0] model_pm(input int k);
        logic [15:0] p;
        for (int r = 0; r < 16; r++) p[r] = (m_ready[k][r] > m_vt);
        return p;
    endfunction

    function automatic logic [3:0] model_hz(input int k);
        logic [15:0] p;
        logic [3:0]  h;
        p = model_pm(k);
        for (int i = 0; i < 4; i++) h[i] = readEnable[i] && p[readRegTag[i]];
        return h;
    endfunction

    function automatic logic model_stall(input int k);
        return freeze || (issueValid && ((|model_hz(k)) || (privilegeLevel && (m_ctrl[k] > m_vt))));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 16; r++) m_ready[k][r] = 0;
                m_ctrl[k] = 0;
            end
            m_vt     = 0;
            model_ok = 1'b1;
        end else if (!freeze) begin
            for (int k = 0; k < 2; k++) begin
                if (issueValid && !model_stall(k) && !flush) begin
                    if (issueWritesReg) begin
                        int lat;
                        lat = (int'(issueLatency) > maxl[k]) ? maxl[k] : int'(issueLatency);
                        if (m_vt + 1 + lat > m_ready[k][issueRegTag])
                            m_ready[k][issueRegTag] = m_vt + 1 + lat;
                    end
                    if (issueSetsControlFlags) m_ctrl[k] = m_vt + 1 + 2;
                end
            end
            m_vt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("m0_stall", 16'(stall0), 16'(model_stall(0)));
            check("m0_hazard", 16'(hz0), 16'(model_hz(0)));
            check("m0_pending", pm0, model_pm(0));
            check("m1_stall", 16'(stall1), 16'(model_stall(1)));
            check("m1_hazard", 16'(hz1), 16'(model_hz(1)));
            check("m1_pending", pm1, model_pm(1));
        end
    end

    task automatic clear_inputs();
        readRegTag            = '0;
        readEnable            = '0;
        issueValid            = 1'b0;
        issueWritesReg        = 1'b0;
        issueRegTag           = '0;
        issueLatency          = '0;
        issueSetsControlFlags = 1'b0;
        privilegeLevel        = 1'b0;
        freeze                = 1'b0;
        flush                 = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (10) next();
    endtask

    task automatic issue(input logic [3:0] tag, input logic [2:0] lat);
        issueValid     = 1'b1;
        issueWritesReg = 1'b1;
        issueRegTag    = tag;
        issueLatency   = lat;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (3) next();
        reset = 1'b0;
        @(negedge clk);
        check("reset_pending", pm0, 16'h0000);
        check("reset_hazard", 16'(hz0), 16'h0);
        check("reset_stall", 16'(stall0), 16'h0);
        next();

        // Load-use: R3 latency 2, reader on port 0 stalls two cycles.
        issue(4'd3, 3'd2);
        for (int c = 1; c <= 3; c++) begin
            next();
            clear_inputs();
            issueValid    = 1'b1;
            readRegTag[0] = 4'd3;
            readEnable    = 4'b0001;
            @(negedge clk);
            check($sformatf("lu_stall_t%0d", c), 16'(stall0), 16'(c <= 2));
            check($sformatf("lu_hazard_t%0d", c), 16'(hz0), (c <= 2) ? 16'h1 : 16'h0);
        end
        settle();
        issue(4'd3, 3'd2);
        next();
        clear_inputs();
        issueValid    = 1'b1;
        readRegTag[0] = 4'd4;
        readEnable    = 4'b0001;
        @(negedge clk);
        check("lu_other_reg_stall", 16'(stall0), 16'h0);
        settle();

        // WAW: long writer then short writer to R5; entry lives until t+6.
        issue(4'd5, 3'd5);
        next();
        issue(4'd5, 3'd1);
        for (int c = 2; c <= 6; c++) begin
            next();
            clear_inputs();
            @(negedge clk);
            check($sformatf("waw_pending_t%0d", c), 16'(pm0[5]), 16'(c < 6));
        end
        settle();

        // Freeze: two frozen cycles extend the R2 stall by two; no accept while frozen.
        issue(4'd2, 3'd3);
        for (int c = 1; c <= 6; c++) begin
            next();
            clear_inputs();
            issue(4'd8, 3'd4);
            readRegTag[0] = 4'd2;
            readEnable    = 4'b0001;
            freeze        = (c <= 2);
            @(negedge clk);
            check($sformatf("frz_stall_t%0d", c), 16'(stall0), 16'(c <= 5));
            check($sformatf("frz_no_accept_t%0d", c), 16'(pm0[8]), 16'h0);
        end
        next();
        clear_inputs();
        @(negedge clk);
        check("frz_late_accept", 16'(pm0[8]), 16'h1);
        settle();

        // Privileged control-flag writer blocks issue for two cycles.
        privilegeLevel        = 1'b1;
        issueValid            = 1'b1;
        issueSetsControlFlags = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            next();
            issueSetsControlFlags = 1'b0;
            @(negedge clk);
            check($sformatf("ctrl_priv_stall_t%0d", c), 16'(stall0), 16'(c <= 2));
        end
        settle();
        issueValid            = 1'b1;
        issueSetsControlFlags = 1'b1;
        next();
        issueSetsControlFlags = 1'b0;
        @(negedge clk);
        check("ctrl_user_stall", 16'(stall0), 16'h0);
        settle();
        privilegeLevel        = 1'b1;
        issueValid            = 1'b1;
        issueSetsControlFlags = 1'b1;
        next();
        issueSetsControlFlags = 1'b0;
        @(negedge clk);
        check("ctrl_drop_before", 16'(stall0), 16'h1);
        next();
        privilegeLevel = 1'b0;
        @(negedge clk);
        check("ctrl_drop_release", 16'(stall0), 16'h0);
        settle();

        // Flush blocks the accept; disabled port never hazards.
        issue(4'd7, 3'd4);
        flush = 1'b1;
        next();
        clear_inputs();
        @(negedge clk);
        check("flush_pending", 16'(pm0[7]), 16'h0);
        issue(4'd7, 3'd4);
        next();
        clear_inputs();
        issueValid    = 1'b1;
        readRegTag[1] = 4'd7;
        readEnable    = 4'b1101;
        @(negedge clk);
        check("dis_port_hazard", 16'(hz0), 16'h0);
        check("dis_port_stall", 16'(stall0), 16'h0);
        next();
        readEnable = 4'b0010;
        @(negedge clk);
        check("en_port_hazard", 16'(hz0), 16'h2);
        settle();

        // Clamp: latency 7 holds 7 cycles on dut0 but is clamped to 6 on dut1.
        issue(4'd9, 3'd7);
        for (int c = 1; c <= 8; c++) begin
            next();
            clear_inputs();
            @(negedge clk);
            check($sformatf("clamp6_pending_t%0d", c), 16'(pm1[9]), 16'(c <= 6));
            check($sformatf("clamp7_pending_t%0d", c), 16'(pm0[9]), 16'(c <= 7));
        end
        settle();

        // Reset mid-operation wipes pending entries.
        issue(4'd1, 3'd5);
        next();
        clear_inputs();
        next();
        reset         = 1'b1;
        issueValid    = 1'b1;
        readRegTag[0] = 4'd1;
        readEnable    = 4'b0001;
        @(negedge clk);
        check("rst_before_stall", 16'(stall0), 16'h1);
        next();
        reset  = 1'b0;
        freeze = 1'b1;
        @(negedge clk);
        check("rst_after_pending", pm0, 16'h0000);
        check("rst_after_hazard", 16'(hz0), 16'h0);
        check("rst_after_stall_frz", 16'(stall0), 16'h1);
        next();
        freeze = 1'b0;
        @(negedge clk);
        check("rst_after_stall", 16'(stall0), 16'h0);
        settle();

        // Random traffic on a small register window to force frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            next();
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) readRegTag[i] = 4'($urandom_range(0, 5));
            readEnable            = 4'($urandom_range(0, 15));
            issueValid            = ($urandom_range(0, 3) != 0);
            issueWritesReg        = ($urandom_range(0, 3) != 0);
            issueRegTag           = 4'($urandom_range(0, 5));
            issueLatency          = 3'($urandom_range(0, 7));
            issueSetsControlFlags = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) privilegeLevel = ~privilegeLevel;
            freeze                = ($urandom_range(0, 7) == 0);
            flush                 = ($urandom_range(0, 9) == 0);
        end
        next();
        clear_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
